// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: raster-stream multi-kernel 2D convolution with line buffers and valid/ready output
module conv2d_stream_engine #(
   parameter int DW = 8,
   parameter int KMAX = 5,
   parameter int NOK = 3,
   parameter int IMG_MAX = 32,
   parameter int ACC_W = 2*DW+$clog2(KMAX*KMAX)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [$clog2(IMG_MAX+1)-1:0]   cfg_img_len,
   input  logic [2:0]                     cfg_ker_len,
   input  logic [1:0]                     cfg_stride,
   input  logic [NOK*KMAX*KMAX*DW-1:0]    ker,
   input  logic [DW-1:0]                  in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [NOK*ACC_W-1:0]           out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [$clog2(IMG_MAX)-1:0]     out_row,
   output logic [$clog2(IMG_MAX)-1:0]     out_col,
   output logic                           busy,
   output logic                           done,
   output logic                           cfg_err
);
   localparam int LW = $clog2(IMG_MAX+1);
   localparam int CW = LW+1;
   localparam int OW = $clog2(IMG_MAX);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state;
   logic [LW-1:0] l_len;
   logic [2:0] k_len, k_off;
   logic [1:0] s_len;
   logic signed [DW-1:0] kreg [NOK][KMAX][KMAX];
   logic [DW-1:0] lb [KMAX-1][IMG_MAX];
   logic signed [DW-1:0] win [KMAX][KMAX];
   logic signed [DW-1:0] s1 [KMAX][KMAX];
   logic signed [ACC_W-1:0] sum [NOK];
   logic [CW-1:0] prow, pcol, nrow, ncol;
   logic [OW-1:0] orow, ocol, t0_row, t0_col, t1_row, t1_col;
   logic v0, v1, en, accept, wv, last_col, last_pix, cfg_ok, drained;
   assign en = !(out_valid && !out_ready);
   assign in_ready = (state == RUN) && en;
   assign accept = in_valid && in_ready;
   assign last_col = pcol + CW'(1) == CW'(l_len);
   assign last_pix = last_col && (prow + CW'(1) == CW'(l_len));
   assign wv = (prow == nrow) && (pcol == ncol);
   assign k_off = 3'(KMAX) - cfg_ker_len;
   assign cfg_ok = cfg_ker_len != '0 && cfg_ker_len <= 3'(KMAX) && cfg_stride != '0 &&
                   cfg_img_len >= LW'(cfg_ker_len) && cfg_img_len <= LW'(IMG_MAX);
   assign drained = !v0 && !v1 && (!out_valid || out_ready);
   always_comb begin
      for (int n = 0; n < NOK; n++) begin
         sum[n] = '0;
         for (int r = 0; r < KMAX; r++)
            for (int c = 0; c < KMAX; c++)
               sum[n] = sum[n] + ACC_W'(s1[r][c]) * ACC_W'(kreg[n][r][c]);
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         {l_len, k_len, s_len} <= '0;
         {prow, pcol, nrow, ncol} <= '0;
         {orow, ocol, t0_row, t0_col, t1_row, t1_col} <= '0;
         {v0, v1, out_valid, busy, done, cfg_err} <= '0;
         {out_data, out_row, out_col} <= '0;
         for (int n = 0; n < NOK; n++)
            for (int r = 0; r < KMAX; r++)
               for (int c = 0; c < KMAX; c++) kreg[n][r][c] <= '0;
         for (int r = 0; r < KMAX; r++)
            for (int c = 0; c < KMAX; c++) begin
               win[r][c] <= '0;
               s1[r][c] <= '0;
            end
         for (int r = 0; r < KMAX-1; r++)
            for (int c = 0; c < IMG_MAX; c++) lb[r][c] <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start && !done) begin
            cfg_err <= !cfg_ok;
            if (cfg_ok) begin
               state <= RUN;
               busy <= 1'b1;
               {l_len, k_len, s_len} <= {cfg_img_len, cfg_ker_len, cfg_stride};
               {prow, pcol, orow, ocol} <= '0;
               nrow <= CW'(cfg_ker_len) - CW'(1);
               ncol <= CW'(cfg_ker_len) - CW'(1);
               // kernels are right/bottom aligned so the K x K taps meet the newest window corner
               for (int n = 0; n < NOK; n++)
                  for (int r = 0; r < KMAX; r++)
                     for (int c = 0; c < KMAX; c++)
                        kreg[n][r][c] <= (r >= int'(k_off) && c >= int'(k_off)) ?
                           ker[((n*KMAX + r - int'(k_off))*KMAX + c - int'(k_off))*DW +: DW] : '0;
            end
         end
         if (state == DRAIN && drained) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
         end
         if (accept) begin
            if (last_pix) state <= DRAIN;
            v0 <= wv;
            t0_row <= orow;
            t0_col <= ocol;
            pcol <= last_col ? '0 : pcol + CW'(1);
            if (last_col) begin
               prow <= prow + CW'(1);
               ncol <= CW'(k_len) - CW'(1);
               ocol <= '0;
               if (prow == nrow) begin
                  nrow <= nrow + CW'(s_len);
                  orow <= orow + OW'(1);
               end
            end else if (pcol == ncol) begin
               ncol <= ncol + CW'(s_len);
               ocol <= ocol + OW'(1);
            end
            for (int r = 0; r < KMAX; r++)
               for (int c = 0; c < KMAX-1; c++) win[r][c] <= win[r][c+1];
            for (int r = 0; r < KMAX-1; r++) win[r][KMAX-1] <= lb[r][pcol[OW-1:0]];
            win[KMAX-1][KMAX-1] <= in_data;
            for (int r = 0; r < KMAX-2; r++) lb[r][pcol[OW-1:0]] <= lb[r+1][pcol[OW-1:0]];
            lb[KMAX-2][pcol[OW-1:0]] <= in_data;
         end else if (en) v0 <= 1'b0;
         if (en) begin
            v1 <= v0;
            if (v0) begin
               s1 <= win;
               t1_row <= t0_row;
               t1_col <= t0_col;
            end
            out_valid <= v1;
            if (v1) begin
               for (int n = 0; n < NOK; n++) out_data[n*ACC_W +: ACC_W] <= sum[n];
               out_row <= t1_row;
               out_col <= t1_col;
            end
         end
      end
   end
endmodule
